// File: rtl/msg_chan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msg_chan_pkg
//  Description : Shared definitions for the message channel arbiter: FSM
//                state encoding, default parameter values, counter widths
//                and a modulo-increment helper used for the round-robin
//                pointer.
//  Contents    : arb_state_t      - IDLE / SEND state encoding
//                c_nreq_def       - default requester count
//                c_dw_def         - default beat data width
//                c_tmo_def        - default stall timeout (cycles)
//                c_cnt_w          - completed-message counter width
//                c_stall_w        - stall counter width (covers TMO <= 255)
//                wrap_inc()       - (v + 1) mod n
//  Revision    : 1.0 - initial release
// ============================================================================
package msg_chan_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    localparam int unsigned c_nreq_def = 4;
    localparam int unsigned c_dw_def   = 8;
    localparam int unsigned c_tmo_def  = 16;

    localparam int unsigned c_cnt_w    = 16;
    localparam int unsigned c_stall_w  = 8;

    // Modulo increment for requester indices; n is the number of requesters.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Scans the request
//                vector starting at index ptr and wrapping modulo NREQ; the
//                first asserted request wins.
//  Ports       : req  [NREQ-1:0]          in   request vector
//                ptr  [clog2(NREQ)-1:0]   in   highest-priority index
//                gnt  [NREQ-1:0]          out  one-hot grant (0 if none)
//                idx  [clog2(NREQ)-1:0]   out  index of the grant
//                any                      out  at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import msg_chan_pkg::*;
#(
    parameter int unsigned NREQ = c_nreq_def
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int unsigned c_iw = $clog2(NREQ);

    int unsigned w_pos;

    // Visit ptr, ptr+1, ... (mod NREQ); the 'any' flag blocks later hits so
    // the earliest position in rotation order is the one granted.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        w_pos = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_pos = (32'(ptr) + k) % NREQ;
            if (!any && req[w_pos]) begin
                any        = 1'b1;
                gnt[w_pos] = 1'b1;
                idx        = c_iw'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/msg_chan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : msg_chan_arbiter
//  Description : Arbitrates NREQ framed message sources onto one shared
//                channel. In IDLE a round-robin pick is made among
//                requesters presenting a head beat; the winner owns the
//                channel in SEND until its tail beat transfers or until it
//                withholds valid for TMO consecutive cycles (forced release).
//  Ports       : clk                      in   rising-edge clock
//                rst_n                    in   asynchronous active-low reset
//                req_valid/head/tail[N]   in   per-requester beat qualifiers
//                req_data [N*DW]          in   requester i at [i*DW +: DW]
//                req_ready[N]             out  per-requester beat accepted
//                ch_valid/head/tail       out  channel beat qualifiers
//                ch_data  [DW]            out  channel data
//                ch_src   [clog2(N)]      out  granted requester index
//                ch_ready                 in   downstream accepts beat
//                msg_ip                   out  high while in SEND
//                err_timeout              out  one-cycle pulse on forced release
//                msg_count[16]            out  completed messages (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_chan_arbiter
    import msg_chan_pkg::*;
#(
    parameter int unsigned NREQ = c_nreq_def,
    parameter int unsigned DW   = c_dw_def,
    parameter int unsigned TMO  = c_tmo_def
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_head,
    input  logic [NREQ-1:0]         req_tail,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    ch_valid,
    output logic                    ch_head,
    output logic                    ch_tail,
    output logic [DW-1:0]           ch_data,
    output logic [$clog2(NREQ)-1:0] ch_src,
    input  logic                    ch_ready,
    output logic                    msg_ip,
    output logic                    err_timeout,
    output logic [15:0]             msg_count
);

    localparam int unsigned c_iw = $clog2(NREQ);
    localparam logic [c_stall_w-1:0] c_tmo_lim = c_stall_w'(TMO);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t           r_state,    w_state_nxt;
    logic [c_iw-1:0]      r_rr,       w_rr_nxt;
    logic [c_iw-1:0]      r_grant,    w_grant_nxt;
    logic [NREQ-1:0]      r_grant_oh, w_grant_oh_nxt;
    logic [c_stall_w-1:0] r_stall,    w_stall_nxt;
    logic [c_cnt_w-1:0]   r_count,    w_count_nxt;
    logic                 r_tmo,      w_tmo_nxt;

    // ------------------------------------------------------------------
    // Round-robin pick among requesters presenting a head beat
    // ------------------------------------------------------------------
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_pick_gnt;
    logic [c_iw-1:0] w_pick_idx;
    logic            w_pick_any;

    assign w_elig = req_valid & req_head;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req  (w_elig),
        .ptr  (r_rr),
        .gnt  (w_pick_gnt),
        .idx  (w_pick_idx),
        .any  (w_pick_any)
    );

    // ------------------------------------------------------------------
    // Granted requester's beat, selected by the registered grant index
    // ------------------------------------------------------------------
    logic          w_g_valid;
    logic          w_g_head;
    logic          w_g_tail;
    logic [DW-1:0] w_g_data;

    always_comb begin
        w_g_valid = 1'b0;
        w_g_head  = 1'b0;
        w_g_tail  = 1'b0;
        w_g_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (c_iw'(i) == r_grant) begin
                w_g_valid = req_valid[i];
                w_g_head  = req_head[i];
                w_g_tail  = req_tail[i];
                w_g_data  = req_data[i*DW +: DW];
            end
        end
    end

    logic [c_iw-1:0]      w_rr_after;
    logic [c_stall_w-1:0] w_stall_inc;

    // Pointer moves past the owner on both normal completion and forced
    // release, so a stalled requester cannot immediately re-win.
    assign w_rr_after  = c_iw'(wrap_inc(32'(r_grant), NREQ));
    assign w_stall_inc = r_stall + 1'b1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr       <= '0;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_stall    <= '0;
            r_count    <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_oh <= w_grant_oh_nxt;
            r_stall    <= w_stall_nxt;
            r_count    <= w_count_nxt;
            r_tmo      <= w_tmo_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and channel outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_grant_nxt    = r_grant;
        w_grant_oh_nxt = r_grant_oh;
        w_stall_nxt    = r_stall;
        w_count_nxt    = r_count;
        w_tmo_nxt      = 1'b0;
        req_ready      = '0;
        ch_valid       = 1'b0;
        ch_head        = 1'b0;
        ch_tail        = 1'b0;
        ch_data        = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt    = ST_SEND;
                    w_grant_nxt    = w_pick_idx;
                    w_grant_oh_nxt = w_pick_gnt;
                    w_stall_nxt    = '0;
                end
            end

            ST_SEND: begin
                ch_valid  = w_g_valid;
                ch_head   = w_g_head;
                ch_tail   = w_g_tail;
                ch_data   = w_g_data;
                req_ready = r_grant_oh & {NREQ{ch_ready}};

                if (w_g_valid && ch_ready && w_g_tail) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = w_rr_after;
                    w_count_nxt = r_count + 1'b1;
                    w_stall_nxt = '0;
                end else if (w_g_valid) begin
                    // Backpressure with valid held is not a stall.
                    w_stall_nxt = '0;
                end else if (w_stall_inc == c_tmo_lim) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = w_rr_after;
                    w_tmo_nxt   = 1'b1;
                    w_stall_nxt = '0;
                end else begin
                    w_stall_nxt = w_stall_inc;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ch_src      = r_grant;
    assign msg_ip      = (r_state == ST_SEND);
    assign err_timeout = r_tmo;
    assign msg_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_msg_chan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_chan_arbiter
//  Description : Self-checking bench for msg_chan_arbiter. Requesters are
//                driven by small message sources; a reference model predicts
//                each cycle's channel behaviour from the arbitration rules
//                and queues expectations for an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_chan_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid, req_head, req_tail, req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic              ch_valid, ch_head, ch_tail, ch_ready;
    logic [DW-1:0]     ch_data;
    logic [1:0]        ch_src;
    logic              msg_ip, err_timeout;
    logic [15:0]       msg_count;

    always #5 clk = ~clk;

    msg_chan_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail),
        .req_data(req_data), .req_ready(req_ready),
        .ch_valid(ch_valid), .ch_head(ch_head), .ch_tail(ch_tail),
        .ch_data(ch_data), .ch_src(ch_src), .ch_ready(ch_ready),
        .msg_ip(msg_ip), .err_timeout(err_timeout), .msg_count(msg_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Message sources
    // ------------------------------------------------------------------
    int rem [NREQ];
    int pos [NREQ];
    bit drop[NREQ];
    bit nohead[NREQ];

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (rem[i] > 0) && !drop[i];
            req_head[i]  = (pos[i] == 0) && !nohead[i];
            req_tail[i]  = (rem[i] == 1);
            req_data[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        #3;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                rem[i]--;
                pos[i]++;
                if (rem[i] == 0) pos[i] = 0;
            end
        end
        drive_inputs();
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner / pointer / idle-count bookkeeping in ints
    // ------------------------------------------------------------------
    typedef struct {
        bit            ip, to, cv, ch, ct;
        bit [NREQ-1:0] rdy;
        bit [DW-1:0]   cd;
        int            src, cnt;
    } exp_t;
    typedef struct { int src; bit [DW-1:0] d; bit t; } beat_t;
    typedef struct { int cyc; int src; bit h; bit t; } log_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];
    log_t  xlog[$];

    bit m_send, m_to, m_found;
    int m_g, m_rr, m_stall, m_cnt, m_j;
    exp_t  me;
    beat_t mb;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_send = 0; m_to = 0; m_g = 0; m_rr = 0; m_stall = 0; m_cnt = 0;
            exp_q.delete();
            beat_q.delete();
        end else begin
            me.ip = m_send; me.to = m_to; me.src = m_g; me.cnt = m_cnt;
            me.cv = 0; me.ch = 0; me.ct = 0; me.cd = '0; me.rdy = '0;
            m_to = 0;
            if (!m_send) begin
                m_found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    m_j = (m_rr + k) % NREQ;
                    if (!m_found && req_valid[m_j] && req_head[m_j]) begin
                        m_found = 1; m_send = 1; m_g = m_j; m_stall = 0;
                    end
                end
            end else begin
                me.cv = req_valid[m_g];
                me.ch = req_head[m_g];
                me.ct = req_tail[m_g];
                me.cd = req_data[m_g*DW +: DW];
                me.rdy[m_g] = ch_ready;
                if (req_valid[m_g] && ch_ready) begin
                    mb.src = m_g; mb.d = req_data[m_g*DW +: DW]; mb.t = req_tail[m_g];
                    beat_q.push_back(mb);
                end
                if (req_valid[m_g] && ch_ready && req_tail[m_g]) begin
                    m_send = 0; m_rr = (m_g + 1) % NREQ; m_cnt = (m_cnt + 1) % 65536; m_stall = 0;
                end else if (req_valid[m_g]) begin
                    m_stall = 0;
                end else begin
                    m_stall++;
                    if (m_stall == TMO) begin
                        m_send = 0; m_rr = (m_g + 1) % NREQ; m_to = 1; m_stall = 0;
                    end
                end
            end
            exp_q.push_back(me);
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int to_pulses = 0;
    int ip_cycles = 0;
    bit r1_ready_seen = 0;
    exp_t  ce;
    beat_t cb;
    log_t  cl;

    always @(negedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            check("msg_ip", msg_ip, ce.ip);
            check("err_timeout", err_timeout, ce.to);
            check("ch_valid", ch_valid, ce.cv);
            check("req_ready", req_ready, ce.rdy);
            check("ch_src", ch_src, ce.src);
            check("msg_count", msg_count, ce.cnt);
            if (ce.cv) begin
                check("ch_head", ch_head, ce.ch);
                check("ch_tail", ch_tail, ce.ct);
                check("ch_data", ch_data, ce.cd);
            end
        end
        if (rst_n) begin
            if (msg_ip) ip_cycles++;
            if (err_timeout) to_pulses++;
            if (req_ready[1]) r1_ready_seen = 1;
            if (ch_valid && ch_ready) begin
                cl.cyc = cyc; cl.src = ch_src; cl.h = ch_head; cl.t = ch_tail;
                xlog.push_back(cl);
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    cb = beat_q.pop_front();
                    check("beat_src", ch_src, cb.src);
                    check("beat_data", ch_data, cb.d);
                    check("beat_tail", ch_tail, cb.t);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_msg_ip"}, msg_ip, 0);
        check({tag, "_ch_valid"}, ch_valid, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_msg_count"}, msg_count, 0);
        check({tag, "_ch_src"}, ch_src, 0);
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; pos[i] = 0; drop[i] = 0; nohead[i] = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int ip0;
    bit got;

    initial begin
        clear_sources();
        ch_ready = 1'b0;
        drive_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Two heads after reset: 0 wins, 2 follows after one idle cycle.
        rem[0] = 2; rem[2] = 2; ch_ready = 1'b1;
        drive_inputs();
        xlog.delete();
        repeat (8) step();
        check("s1_beats", xlog.size(), 4);
        if (xlog.size() == 4) begin
            check("s1_first_src", xlog[0].src, 0);
            check("s1_first_head", xlog[0].h, 1);
            check("s1_tail_src", xlog[1].src, 0);
            check("s1_second_src", xlog[2].src, 2);
            check("s1_idle_gap", xlog[2].cyc - xlog[1].cyc, 2);
        end

        // Three-beat message with 5 cycles of downstream backpressure.
        rem[1] = 3; ch_ready = 1'b1;
        drive_inputs();
        xlog.delete();
        for (int k = 1; k < 15; k++) begin
            step();
            ch_ready = (k < 2 || k > 6);
        end
        check("s2_beats", xlog.size(), 3);
        check("s2_no_timeout", to_pulses, 0);
        check("s2_count", msg_count, 3);

        // Requester 3 granted, then withholds valid past the timeout.
        rem[3] = 2; ch_ready = 1'b1;
        drive_inputs();
        step();
        step();
        drop[3] = 1;
        drive_inputs();
        repeat (20) step();
        check("s3_timeout_pulses", to_pulses, 1);
        check("s3_msg_ip", msg_ip, 0);
        check("s3_count", msg_count, 3);
        rem[3] = 0; pos[3] = 0; drop[3] = 0;
        // Pointer now at 0: order must be 0, 1, 3.
        rem[0] = 1; rem[1] = 1; rem[3] = 1;
        drive_inputs();
        xlog.delete();
        repeat (10) step();
        check("s3_rr_beats", xlog.size(), 3);
        if (xlog.size() == 3) begin
            check("s3_rr_first", xlog[0].src, 0);
            check("s3_rr_second", xlog[1].src, 1);
            check("s3_rr_third", xlog[2].src, 3);
        end

        // Single-beat message: one SEND cycle.
        ip0 = ip_cycles;
        rem[2] = 1;
        drive_inputs();
        repeat (5) step();
        check("s4_ip_cycles", ip_cycles - ip0, 1);
        check("s4_count", msg_count, 7);

        // Valid without head is never granted.
        nohead[1] = 1; rem[1] = 2; r1_ready_seen = 0;
        drive_inputs();
        xlog.delete();
        repeat (12) step();
        check("s5_ready1_seen", r1_ready_seen, 0);
        check("s5_beats", xlog.size(), 0);
        check("s5_msg_ip", msg_ip, 0);
        nohead[1] = 0; rem[1] = 0;

        // Asynchronous reset during the second beat.
        rem[0] = 3;
        drive_inputs();
        xlog.delete();
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (xlog.size() >= 1) got = 1;
        end
        check("s6_first_beat_seen", got, 1);
        check("s6_pre_msg_ip", msg_ip, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("s6");
        clear_sources();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0 && $urandom_range(3) == 0) begin
                    rem[i] = $urandom_range(4, 1);
                    pos[i] = 0;
                end
                drop[i] = ($urandom_range(7) == 0);
            end
            ch_ready = ($urandom_range(3) != 0);
            drive_inputs();
            step();
        end
        clear_sources();
        drive_inputs();
        repeat (3) step();
        check("beat_q_drain", beat_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msg_chan_arbiter.md
MSG_CHAN_ARBITER -- requirements
Module: msg_chan_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DW, default 8: message beat data width.
REQ-003 Parameter TMO, default 16: stall-timeout threshold in cycles, range 2..255.
REQ-004 clock  in  1  sole clock, rising-edge active.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester beat valid.
REQ-007 req_head  in  NREQ  per-requester first-beat marker.
REQ-008 req_tail  in  NREQ  per-requester last-beat marker.
REQ-009 req_data  in  NREQ*DW  per-requester beat data, requester i at bits [i*DW +: DW].
REQ-010 req_ready  out  NREQ  per-requester beat accepted.
REQ-011 ch_valid, ch_head, ch_tail  out  1 each  shared channel beat qualifiers.
REQ-012 ch_data  out  DW  shared channel data.
REQ-013 ch_src  out  clog2(NREQ)  index of the granted requester.
REQ-014 ch_ready  in  1  downstream accepts the beat.
REQ-015 msg_ip  out  1  message in progress, high exactly while in SEND.
REQ-016 err_timeout  out  1  one-cycle pulse on a forced release.
REQ-017 msg_count  out  16  completed-message counter, wraps at 2^16.

Function
REQ-018 The FSM SHALL have two states: IDLE and SEND.
REQ-019 In IDLE, the eligible set SHALL be requesters with req_valid & req_head both 1; req_ready SHALL be all 0 and ch_valid 0.
REQ-020 In IDLE with a non-empty eligible set, the block SHALL grant round-robin starting at pointer rr, register the grant, and enter SEND on the next edge: request-to-grant latency is one cycle.
REQ-021 In SEND, ch_valid/head/tail/data SHALL combinationally mirror the granted requester; req_ready[g] SHALL equal ch_ready; every other req_ready SHALL be 0.
REQ-022 A transfer is defined as ch_valid & ch_ready; a transfer with ch_tail 1 SHALL return the FSM to IDLE, set rr to g+1 mod NREQ, and increment msg_count.
REQ-023 A single-beat message (head and tail both 1) SHALL complete in one SEND cycle.
REQ-024 Between back-to-back messages there SHALL be exactly one IDLE cycle.
REQ-025 A requester asserting valid without head in IDLE is not eligible and SHALL be held (ready 0).
REQ-026 Head beats after the first within a granted message SHALL pass through unchanged; the arbiter does not police framing.
REQ-027 Stall counter: in SEND, it SHALL count consecutive cycles with req_valid[g]==0, clear on any cycle with valid 1, and clear on entry to SEND.
REQ-028 When the stall counter reaches TMO, the block SHALL return to IDLE on that edge, pulse err_timeout for one cycle, advance rr to g+1, and leave msg_count unchanged.
REQ-029 A tail transfer in the same cycle the counter would expire is impossible (valid is 1); tail completion takes priority by construction.
REQ-030 ch_ready low SHALL stall the message indefinitely without timeout (only missing valid counts).
REQ-031 ch_src SHALL hold the last grant value in IDLE.

Reset
REQ-032 Reset assertion SHALL act asynchronously, including mid-message: state IDLE, rr 0, grant 0, stall counter 0, msg_count 0, err_timeout 0, msg_ip 0, all req_ready 0, ch_valid 0.
REQ-033 The first arbitration after reset deassertion SHALL occur on the first rising edge with reset high.

Structure
REQ-034 State encoding (IDLE=0, SEND=1) and the default-parameter constants SHALL reside in shared package msg_chan_pkg.
REQ-035 Round-robin selection SHALL be a sub-module, rr_pick (inputs: request vector and pointer; outputs: one-hot grant and index, combinational).

Verification
REQ-036 Requesters 0 and 2 both present a head in IDLE after reset -> grant 0 first (ch_src 0), then grant 2 after requester 0's tail, with one IDLE cycle between.
REQ-037 Requester 1 sends a 3-beat message with ch_ready low for 5 cycles mid-message -> no err_timeout; msg_count increments by 1; 3 transfers total.
REQ-038 Requester 3 granted, then drops valid for 16 cycles -> err_timeout pulses exactly once, msg_ip falls, and rr becomes 0.
REQ-039 Single beat with head=tail=1 and ch_ready 1 -> msg_ip high for exactly one cycle; msg_count +1.
REQ-040 Reset is asserted during the second beat of a message -> all outputs immediately take reset values, with no clock edge required.
REQ-041 Requester 1 presents valid without head in IDLE -> never granted; req_ready[1] stays 0.
